// File: rtl/cache_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port cache.
//   slave  : arbiter side (receives requests and cache responses, drives
//            rdy, response strobes and the cache request)
//   master : environment side (requesters + cache model), opposite view
// Signals:
//   reqN_vld/rdy/wr/addr/data  request handshake for requester N (0, 1)
//   reqN_rsp_vld/rsp_data      one-cycle read response to requester N
//   cache_req_op/addr/data     registered cache command (0 INVALID, 1 READ, 2 WRITE)
//   cache_rsp_vld/rsp_data     cache read response
//   err_spurious               sticky unexpected-response flag
interface cache_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req0_vld;
  logic                  req0_rdy;
  logic                  req0_wr;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_rsp_vld;
  logic [DATA_WIDTH-1:0] req0_rsp_data;

  logic                  req1_vld;
  logic                  req1_rdy;
  logic                  req1_wr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_rsp_vld;
  logic [DATA_WIDTH-1:0] req1_rsp_data;

  logic [1:0]            cache_req_op;
  logic [ADDR_WIDTH-1:0] cache_req_addr;
  logic [DATA_WIDTH-1:0] cache_req_data;
  logic                  cache_rsp_vld;
  logic [DATA_WIDTH-1:0] cache_rsp_data;
  logic                  err_spurious;

  modport slave (
    input  req0_vld, req0_wr, req0_addr, req0_data,
    input  req1_vld, req1_wr, req1_addr, req1_data,
    input  cache_rsp_vld, cache_rsp_data,
    output req0_rdy, req0_rsp_vld, req0_rsp_data,
    output req1_rdy, req1_rsp_vld, req1_rsp_data,
    output cache_req_op, cache_req_addr, cache_req_data,
    output err_spurious
  );

  modport master (
    output req0_vld, req0_wr, req0_addr, req0_data,
    output req1_vld, req1_wr, req1_addr, req1_data,
    output cache_rsp_vld, cache_rsp_data,
    input  req0_rdy, req0_rsp_vld, req0_rsp_data,
    input  req1_rdy, req1_rsp_vld, req1_rsp_data,
    input  cache_req_op, cache_req_addr, cache_req_data,
    input  err_spurious
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-requester round-robin arbiter in front of a cache that accepts one
// transaction at a time.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cache_arbiter_if.slave: request handshakes, read responses,
//          registered cache command, cache response, err_spurious
// Parameters: ADDR_WIDTH, DATA_WIDTH, WRITE_GAP (1..15 idle cycles after a
// write issue before the next grant).
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WRITE_GAP  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_e;
  typedef enum logic [1:0] {
    OP_INVALID = 2'd0,
    OP_READ    = 2'd1,
    OP_WRITE   = 2'd2
  } op_e;

  state_e     state;
  logic       last_grant;  // 1 = req1 granted last, so req0 wins a tie
  logic       cur_id;      // requester owning the outstanding transaction
  logic [3:0] gap_cnt;
  logic       run;         // low until the first clock edge after reset release
  logic       grant0;
  logic       grant1;

  // Grants are only offered once the block has seen a clock edge out of
  // reset, so rdy cannot rise in the middle of the release cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (run && state == IDLE) begin
      if (bus.req0_vld && (!bus.req1_vld || last_grant))
        grant0 = 1'b1;
      else if (bus.req1_vld)
        grant1 = 1'b1;
    end
  end

  assign bus.req0_rdy = grant0;
  assign bus.req1_rdy = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      last_grant         <= 1'b1;
      cur_id             <= 1'b0;
      gap_cnt            <= '0;
      run                <= 1'b0;
      bus.cache_req_op   <= OP_INVALID;
      bus.cache_req_addr <= '0;
      bus.cache_req_data <= '0;
      bus.req0_rsp_vld   <= 1'b0;
      bus.req1_rsp_vld   <= 1'b0;
      bus.req0_rsp_data  <= '0;
      bus.req1_rsp_data  <= '0;
      bus.err_spurious   <= 1'b0;
    end else begin
      run              <= 1'b1;
      bus.req0_rsp_vld <= 1'b0;
      bus.req1_rsp_vld <= 1'b0;
      bus.cache_req_op <= OP_INVALID;

      if (bus.cache_rsp_vld && state != WAIT_RD)
        bus.err_spurious <= 1'b1;

      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            state      <= ISSUE;
            cur_id     <= grant1;
            last_grant <= grant1;
            // The registered cache command doubles as the latched request.
            if (grant1) begin
              bus.cache_req_op   <= bus.req1_wr ? OP_WRITE : OP_READ;
              bus.cache_req_addr <= bus.req1_addr;
              bus.cache_req_data <= bus.req1_data;
            end else begin
              bus.cache_req_op   <= bus.req0_wr ? OP_WRITE : OP_READ;
              bus.cache_req_addr <= bus.req0_addr;
              bus.cache_req_data <= bus.req0_data;
            end
          end
        end
        ISSUE: begin
          if (bus.cache_req_op == OP_WRITE) begin
            state   <= WAIT_WR;
            gap_cnt <= 4'(WRITE_GAP);
          end else begin
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (bus.cache_rsp_vld) begin
            state <= IDLE;
            if (cur_id) begin
              bus.req1_rsp_vld  <= 1'b1;
              bus.req1_rsp_data <= bus.cache_rsp_data;
            end else begin
              bus.req0_rsp_vld  <= 1'b1;
              bus.req0_rsp_data <= bus.cache_rsp_data;
            end
          end
        end
        WAIT_WR: begin
          if (gap_cnt == 4'd1)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations plus
// a transaction-level model checked every cycle on the falling clock edge.
module tb_cache_arbiter;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 8;
  localparam int          GAP = 3;
  localparam int          NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cache_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: each transaction is described by its handshake
  // cycle and the cycle at which the arbiter becomes free again.
  int          cyc = 0;
  bit          m_run, m_busy, m_wr, m_id, m_last, m_err, m_pulse_id;
  int          m_hs, m_free_at, m_pulse_at;
  logic [DW-1:0] m_pulse_data, m_data;
  logic [AW-1:0] m_addr;
  bit          idle, any, w, e0, e1, p0, p1;
  logic [1:0]  eop;

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_wr = 0; m_id = 0; m_last = 1; m_err = 0;
    m_hs = -10; m_free_at = 0; m_pulse_at = -10; m_pulse_id = 0;
    m_pulse_data = '0; m_addr = '0; m_data = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else if (m_busy && cyc >= m_free_at) m_busy = 0;
    idle = !m_busy;
    any  = bus.req0_vld || bus.req1_vld;
    w    = (bus.req0_vld && bus.req1_vld) ? !m_last : !bus.req0_vld;
    e0   = rst_n && m_run && idle && any && !w;
    e1   = rst_n && m_run && idle && any && w;
    eop  = (m_busy && cyc == m_hs + 1) ? (m_wr ? 2'd2 : 2'd1) : 2'd0;
    p0   = (cyc == m_pulse_at) && !m_pulse_id;
    p1   = (cyc == m_pulse_at) && m_pulse_id;

    chk("m_rdy", {bus.req1_rdy, bus.req0_rdy}, {e1, e0});
    chk("m_op", bus.cache_req_op, eop);
    chk("m_addr", bus.cache_req_addr, m_addr);
    chk("m_data", bus.cache_req_data, m_data);
    chk("m_rsp_vld", {bus.req1_rsp_vld, bus.req0_rsp_vld}, {p1, p0});
    chk("m_err", bus.err_spurious, m_err);
    if (p0) chk("m_rsp0_data", bus.req0_rsp_data, m_pulse_data);
    if (p1) chk("m_rsp1_data", bus.req1_rsp_data, m_pulse_data);

    if (rst_n) begin
      if (bus.cache_rsp_vld) begin
        if (m_busy && !m_wr && cyc >= m_hs + 2 && m_free_at == NEVER) begin
          m_pulse_at   = cyc + 1;
          m_pulse_id   = m_id;
          m_pulse_data = bus.cache_rsp_data;
          m_free_at    = cyc + 1;
        end else begin
          m_err = 1;
        end
      end
      if (e0 || e1) begin
        m_busy    = 1;
        m_hs      = cyc;
        m_id      = w;
        m_last    = w;
        m_wr      = w ? bus.req1_wr : bus.req0_wr;
        m_addr    = w ? bus.req1_addr : bus.req0_addr;
        m_data    = w ? bus.req1_data : bus.req0_data;
        m_free_at = m_wr ? cyc + 2 + GAP : NEVER;
      end
      m_run = 1;
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  bit q[$];
  int n;

  initial begin
    rst_n = 1'b0;
    bus.req0_vld = 0; bus.req0_wr = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_vld = 0; bus.req1_wr = 0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.cache_rsp_vld = 0; bus.cache_rsp_data = '0;

    // Reset state
    bus.req0_vld = 1;
    #3;
    chk("reset_rdy", {bus.req1_rdy, bus.req0_rdy}, 2'b00);
    chk("reset_op", bus.cache_req_op, 2'd0);
    chk("reset_addr", bus.cache_req_addr, 6'h00);
    chk("reset_data", bus.cache_req_data, 8'h00);
    chk("reset_rsp_vld", {bus.req1_rsp_vld, bus.req0_rsp_vld}, 2'b00);
    chk("reset_rsp_data", {bus.req1_rsp_data, bus.req0_rsp_data}, 16'h0000);
    chk("reset_err", bus.err_spurious, 1'b0);
    bus.req0_vld = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    tick(); tick();

    // Fairness: both hold vld with writes for six grants
    bus.req0_wr = 1; bus.req0_addr = 6'h01; bus.req0_data = 8'h10;
    bus.req1_wr = 1; bus.req1_addr = 6'h02; bus.req1_data = 8'h20;
    bus.req0_vld = 1; bus.req1_vld = 1;
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      #1;
      if (bus.req0_rdy) begin q.push_back(1'b0); n++; end
      else if (bus.req1_rdy) begin q.push_back(1'b1); n++; end
      tick();
    end
    bus.req0_vld = 0; bus.req1_vld = 0;
    chk("fair_count", n, 6);
    for (int i = 0; i < q.size(); i++) chk("fair_order", q[i], i % 2);
    repeat (8) tick();

    // Single read: req0 addr 0x05, cache answers 0xA7 in cycle 4
    bus.req0_wr = 0; bus.req0_addr = 6'h05; bus.req0_vld = 1;
    #1 chk("rd_grant", bus.req0_rdy, 1'b1);
    tick(); bus.req0_vld = 0; bus.req0_addr = 6'h06;
    #1 chk("rd_op_c1", bus.cache_req_op, 2'd1);
    chk("rd_addr_c1", bus.cache_req_addr, 6'h05);
    tick(); chk("rd_op_c2", bus.cache_req_op, 2'd0);
    tick();
    tick(); bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'hA7;
    tick(); bus.cache_rsp_vld = 0;
    #1 chk("rd_rsp_vld_c5", {bus.req1_rsp_vld, bus.req0_rsp_vld}, 2'b01);
    chk("rd_rsp_data_c5", bus.req0_rsp_data, 8'hA7);
    tick(); chk("rd_rsp_vld_c6", {bus.req1_rsp_vld, bus.req0_rsp_vld}, 2'b00);

    // Write gap: req1 write 0x3F/0x5C, req0 waits for its grant in cycle 5
    bus.req1_wr = 1; bus.req1_addr = 6'h3F; bus.req1_data = 8'h5C; bus.req1_vld = 1;
    #1 chk("wr_grant", bus.req1_rdy, 1'b1);
    tick(); bus.req1_vld = 0;
    bus.req0_wr = 0; bus.req0_addr = 6'h10; bus.req0_vld = 1;
    #1 chk("wr_op_c1", bus.cache_req_op, 2'd2);
    chk("wr_addr_c1", bus.cache_req_addr, 6'h3F);
    chk("wr_data_c1", bus.cache_req_data, 8'h5C);
    chk("wr_rdy0_c1", bus.req0_rdy, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("wr_op_gap", bus.cache_req_op, 2'd0);
      chk("wr_rdy0_gap", bus.req0_rdy, 1'b0);
    end
    tick(); chk("wr_rdy0_c5", bus.req0_rdy, 1'b1);
    tick(); bus.req0_vld = 0;
    tick(); bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'h11;
    tick(); bus.cache_rsp_vld = 0;
    #1 chk("wr_follow_rsp", {bus.req1_rsp_vld, bus.req0_rsp_vld, bus.req0_rsp_data}, {2'b01, 8'h11});
    tick();

    // Back-to-back: req0 keeps vld, regrant in the rsp_vld cycle
    bus.req0_wr = 0; bus.req0_addr = 6'h21; bus.req0_vld = 1;
    #1 chk("b2b_grant", bus.req0_rdy, 1'b1);
    tick(); bus.req0_addr = 6'h22;
    #1 chk("b2b_addr_held", bus.cache_req_addr, 6'h21);
    tick(); bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'h99;
    tick(); bus.cache_rsp_vld = 0;
    #1 chk("b2b_rsp", {bus.req1_rsp_vld, bus.req0_rsp_vld, bus.req0_rsp_data}, {2'b01, 8'h99});
    chk("b2b_regrant", bus.req0_rdy, 1'b1);
    tick(); bus.req0_vld = 0;
    #1 chk("b2b_op2", {bus.cache_req_op, bus.cache_req_addr}, {2'd1, 6'h22});
    tick(); bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'h42;
    tick(); bus.cache_rsp_vld = 0;
    #1 chk("b2b_rsp2", {bus.req0_rsp_vld, bus.req0_rsp_data}, {1'b1, 8'h42});
    tick();

    // Spurious response while idle
    chk("sp_err_before", bus.err_spurious, 1'b0);
    bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'hEE;
    tick(); bus.cache_rsp_vld = 0;
    chk("sp_err", bus.err_spurious, 1'b1);
    chk("sp_no_rsp", {bus.req1_rsp_vld, bus.req0_rsp_vld}, 2'b00);
    repeat (3) tick();
    chk("sp_err_sticky", bus.err_spurious, 1'b1);

    // Reset mid-read: req1 read, reset in WAIT_RD
    bus.req1_wr = 0; bus.req1_addr = 6'h07; bus.req1_vld = 1;
    #1 chk("rr_grant", bus.req1_rdy, 1'b1);
    tick(); bus.req1_vld = 0;
    tick();
    #1 rst_n = 1'b0;
    bus.req0_vld = 1; bus.req1_vld = 1;
    #1 chk("rr_op", bus.cache_req_op, 2'd0);
    chk("rr_addr_data", {bus.cache_req_addr, bus.cache_req_data}, 14'h0);
    chk("rr_rsp", {bus.req1_rsp_vld, bus.req0_rsp_vld}, 2'b00);
    chk("rr_err", bus.err_spurious, 1'b0);
    chk("rr_rdy", {bus.req1_rdy, bus.req0_rdy}, 2'b00);
    tick(); tick();
    #2 rst_n = 1'b1;
    #1 chk("rr_rdy_release", {bus.req1_rdy, bus.req0_rdy}, 2'b00);
    tick();
    chk("rr_next_grant", {bus.req1_rdy, bus.req0_rdy}, 2'b01);
    bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'h55;
    tick(); bus.cache_rsp_vld = 0; bus.req0_vld = 0; bus.req1_vld = 0;
    #1 chk("rr_late_err", bus.err_spurious, 1'b1);
    chk("rr_late_no_rsp", {bus.req1_rsp_vld, bus.req0_rsp_vld}, 2'b00);
    tick(); bus.cache_rsp_vld = 1; bus.cache_rsp_data = 8'h3C;
    tick(); bus.cache_rsp_vld = 0;
    #1 chk("rr_after_rsp", {bus.req1_rsp_vld, bus.req0_rsp_vld, bus.req0_rsp_data}, {2'b01, 8'h3C});
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 6, cache address width.
- DATA_WIDTH, 8, cache data width.
- WRITE_GAP, 3, idle cycles after a write issue before the next grant; legal range 1..15.

REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- reqN_vld  input  1  requester N has a request (N = 0, 1; same for every reqN_ port).
- reqN_rdy  output  1  request accepted this cycle.
- reqN_wr  input  1  1 = write, 0 = read.
- reqN_addr  input  ADDR_WIDTH  request address.
- reqN_data  input  DATA_WIDTH  write data.
- reqN_rsp_vld  output  1  one-cycle read-response strobe.
- reqN_rsp_data  output  DATA_WIDTH  read data; valid only with reqN_rsp_vld.
- cache_req_op  output  2  cache op: INVALID = 2'd0, READ = 2'd1, WRITE = 2'd2.
- cache_req_addr  output  ADDR_WIDTH  cache address.
- cache_req_data  output  DATA_WIDTH  cache write data.
- cache_rsp_vld  input  1  cache read response valid.
- cache_rsp_data  input  DATA_WIDTH  cache read data.
- err_spurious  output  1  sticky: cache_rsp_vld arrived outside WAIT_RD.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_RD, WAIT_WR. At most one cache transaction is outstanding at any time.
REQ-004 In IDLE with any reqN_vld high, the block SHALL raise reqN_rdy combinationally for exactly one winner. rdy SHALL be low for both requesters in all other states.
REQ-005 Winner selection SHALL be round-robin:
- Sole requester wins.
- If both request, the requester not granted last wins.
- After reset, the last-grant pointer favours req0.
REQ-006 On handshake (vld & rdy), the block SHALL latch op, addr, data and requester id, update the pointer, and enter ISSUE next cycle.
REQ-007 cache_req_op, cache_req_addr and cache_req_data SHALL be registered. cache_req_op SHALL be READ or WRITE for exactly the one ISSUE cycle and INVALID in every other cycle. Addr and data SHALL hold their last values outside ISSUE.
REQ-008 ISSUE SHALL go to WAIT_RD for a read, or to WAIT_WR with its countdown loaded to WRITE_GAP for a write.
REQ-009 In WAIT_RD, the first cycle with cache_rsp_vld high SHALL:
- register cache_rsp_data into the latched requester's rsp_data;
- pulse that requester's rsp_vld for one cycle on the next cycle;
- move the FSM to IDLE in that same next cycle.
The other requester's rsp_vld SHALL stay low.
REQ-010 WAIT_RD SHALL wait indefinitely; there is no timeout.
REQ-011 WAIT_WR SHALL last exactly WRITE_GAP cycles, then go to IDLE.
REQ-012 cache_rsp_vld high in IDLE, ISSUE or WAIT_WR SHALL:
- be ignored for data;
- set err_spurious, which stays set until reset.
REQ-013 A new grant SHALL be possible in the same cycle the FSM returns to IDLE, including the cycle in which rsp_vld pulses.
REQ-014 Requester inputs SHALL be sampled only at handshake. Changes to them in any other cycle SHALL have no effect.
REQ-015 Latency rules (handshake in cycle 0):
- Read: cache op in cycle 1; cache_rsp_vld in cycle k (k >= 2) gives reqN_rsp_vld in cycle k+1.
- Write: cache op in cycle 1; next grant possible in cycle 2 + WRITE_GAP.

Reset
REQ-016 rst_n low SHALL act asynchronously and force:
- FSM to IDLE, pointer to favour req0;
- cache_req_op = INVALID; cache_req_addr and cache_req_data = 0;
- both rsp_vld = 0, both rsp_data = 0, err_spurious = 0.
REQ-017 Reset during ISSUE, WAIT_RD or WAIT_WR SHALL abandon the transaction with no response pulse. A cache response arriving after reset release SHALL set err_spurious.
REQ-018 rdy SHALL be low while rst_n is low. Release SHALL take effect at the first rising clk edge with rst_n high.

Verification
REQ-019 Bench SHALL cover:
- Single read: req0 read addr 0x05 in cycle 0; cache returns 0xA7 in cycle 4 -> cache_req_op = READ in cycle 1 only; req0_rsp_vld with data 0xA7 in cycle 5; req1_rsp_vld stays low.
- Write gap: req1 write addr 0x3F data 0x5C, WRITE_GAP = 3 -> WRITE/0x3F/0x5C in cycle 1 only; req0_rdy held low through cycle 4, high in cycle 5.
- Fairness: both requesters hold vld for 6 transactions -> grants alternate req0, req1, req0, ...
- Back-to-back: a read completes and req0 keeps vld -> new handshake in the same cycle as the rsp_vld pulse.
- Spurious: cache_rsp_vld pulsed in IDLE -> err_spurious = 1 and stays 1; no rsp_vld on either requester.
- Reset mid-read: rst_n low in WAIT_RD -> all outputs zero/INVALID immediately; no rsp_vld after release; next grant goes to req0.
